// File: rtl/fft_ctrl_pkg.sv
// Shared types for the FFT butterfly controller: FSM state encoding, LED step
// codes and the bundled datapath strobe word.
package fft_ctrl_pkg;

    // 5-bit so that SH_IMZ can live beyond the 4-bit LED code range
    typedef enum logic [4:0] {
        S_IDLE   = 5'd0,
        S_W1     = 5'd1,
        S_W2     = 5'd2,
        S_WAIT_B = 5'd3,
        S_LD_B   = 5'd4,
        S_C_REWB = 5'd5,
        S_C_IMY  = 5'd6,
        S_C_IMZ  = 5'd7,
        S_WAIT_A = 5'd8,
        S_LD_A   = 5'd9,
        S_C_REY  = 5'd10,
        S_C_REZ2 = 5'd11,
        S_C_REZ  = 5'd12,
        S_SH_REY = 5'd13,
        S_SH_IMY = 5'd14,
        S_SH_REZ = 5'd15,
        S_SH_IMZ = 5'd16
    } state_t;

    localparam logic [3:0] STEP_IDLE   = 4'd0;
    localparam logic [3:0] STEP_SH_REZ = 4'd15;
    localparam logic [3:0] STEP_SH_IMZ = 4'd15;

    typedef struct packed {
        logic       store_w;
        logic       store_b;
        logic       store_a;
        logic       calc_rewb;
        logic       calc_imy;
        logic       calc_imz;
        logic       calc_rey;
        logic       calc_rez2;
        logic       calc_rez;
        logic       display_rey;
        logic       display_imy;
        logic       display_rez;
        logic       display_imz;
        logic       clear;
        logic       busy;
        logic [3:0] step;
    } ctrl_t;

    localparam ctrl_t CTRL_NONE = '0;

    // LED code saturates at 15 so the last two result states share it
    function automatic logic [3:0] step_code(input state_t s);
        logic [4:0] code;
        code = s;
        if (code > 5'd15) begin
            return STEP_SH_IMZ;
        end
        return code[3:0];
    endfunction

endpackage

// File: rtl/butterfly_controller_next_pulse_gen.sv
// Turns the asynchronous Next button into a one-cycle pulse per press.
// Optional debounce filter enabled by defining NEXT_DEBOUNCE_EN.
module next_pulse_gen #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter logic [19:0] DEBOUNCE_CYCLES = 20'd500000
) (
    input  logic Clock,
    input  logic nReset,
    input  logic next_i,
    output logic next_pulse_o
);

    // Reset to 1 so a button already held at reset release is not a press
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_lvl;
    logic                   level;
    logic                   prev_q;

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], next_i};
        end
    end

    assign sync_lvl = sync_q[SYNC_STAGES-1];

`ifdef NEXT_DEBOUNCE_EN
    localparam logic [19:0] DEB_RELOAD = DEBOUNCE_CYCLES - 20'd1;

    logic [19:0] cnt_q, cnt_d;
    logic        level_q, level_d;

    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        if (sync_lvl == level_q) begin
            cnt_d = DEB_RELOAD;
        end else if (cnt_q == 20'd0) begin
            level_d = sync_lvl;
            cnt_d   = DEB_RELOAD;
        end else begin
            cnt_d = cnt_q - 20'd1;
        end
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            cnt_q   <= DEB_RELOAD;
            level_q <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    assign level = level_q;
`else
    logic unused_debounce;
    assign unused_debounce = ^DEBOUNCE_CYCLES;
    assign level           = sync_lvl;
`endif

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            prev_q <= 1'b1;
        end else begin
            prev_q <= level;
        end
    end

    assign next_pulse_o = level & ~prev_q;

endmodule

// File: rtl/butterfly_controller.sv
// Moore FSM sequencing the FFT butterfly datapath from a single Next button.
// Define NEXT_DEBOUNCE_EN to add the debounce filter in next_pulse_gen.
//
// state    | meaning
// IDLE     | after reset, datapath result cleared, wait for press
// W1, W2   | load twiddle index, then latch synchronous ROM data
// WAIT_B   | wait for press to load B
// LD_B     | latch B
// C_REWB   | compute Re(W*B)
// C_IMY    | compute Im(Y)
// C_IMZ    | compute Im(Z)
// WAIT_A   | wait for press to load A
// LD_A     | latch A
// C_REY    | compute Re(Y)
// C_REZ2   | first half of Re(Z)
// C_REZ    | finish Re(Z)
// SH_REY.. | show ReY, ImY, ReZ, ImZ, one per press
// SH_IMZ   | last result; next press starts a new butterfly (twiddle kept)
module butterfly_controller
    import fft_ctrl_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter logic [19:0] DEBOUNCE_CYCLES = 20'd500000
) (
    input  logic       Clock,
    input  logic       nReset,
    input  logic       Next,
    output logic       store_W,
    output logic       store_B,
    output logic       store_A,
    output logic       calc_ReWB,
    output logic       calc_ImY,
    output logic       calc_ImZ,
    output logic       calc_ReY,
    output logic       calc_ReZ2,
    output logic       calc_ReZ,
    output logic       display_ReY,
    output logic       display_ImY,
    output logic       display_ReZ,
    output logic       display_ImZ,
    output logic       clear,
    output logic       busy,
    output logic [3:0] step
);

    logic   next_pulse;
    state_t state_q, state_d;
    ctrl_t  ctrl;

    next_pulse_gen #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_next_pulse_gen (
        .Clock        (Clock),
        .nReset       (nReset),
        .next_i       (Next),
        .next_pulse_o (next_pulse)
    );

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ctrl      = CTRL_NONE;
        ctrl.step = step_code(state_q);
        case (state_q)
            S_IDLE: begin
                ctrl.clear = 1'b1;
                if (next_pulse) state_d = S_W1;
            end
            S_W1: begin
                ctrl.store_w = 1'b1;
                ctrl.busy    = 1'b1;
                state_d      = S_W2;
            end
            S_W2: begin
                ctrl.store_w = 1'b1;
                ctrl.busy    = 1'b1;
                state_d      = S_WAIT_B;
            end
            S_WAIT_B: begin
                if (next_pulse) state_d = S_LD_B;
            end
            S_LD_B: begin
                ctrl.store_b = 1'b1;
                ctrl.busy    = 1'b1;
                state_d      = S_C_REWB;
            end
            S_C_REWB: begin
                ctrl.calc_rewb = 1'b1;
                ctrl.busy      = 1'b1;
                state_d        = S_C_IMY;
            end
            S_C_IMY: begin
                ctrl.calc_imy = 1'b1;
                ctrl.busy     = 1'b1;
                state_d       = S_C_IMZ;
            end
            S_C_IMZ: begin
                ctrl.calc_imz = 1'b1;
                ctrl.busy     = 1'b1;
                state_d       = S_WAIT_A;
            end
            S_WAIT_A: begin
                if (next_pulse) state_d = S_LD_A;
            end
            S_LD_A: begin
                ctrl.store_a = 1'b1;
                ctrl.busy    = 1'b1;
                state_d      = S_C_REY;
            end
            S_C_REY: begin
                ctrl.calc_rey = 1'b1;
                ctrl.busy     = 1'b1;
                state_d       = S_C_REZ2;
            end
            S_C_REZ2: begin
                ctrl.calc_rez2 = 1'b1;
                ctrl.busy      = 1'b1;
                state_d        = S_C_REZ;
            end
            S_C_REZ: begin
                ctrl.calc_rez = 1'b1;
                ctrl.busy     = 1'b1;
                state_d       = S_SH_REY;
            end
            S_SH_REY: begin
                ctrl.display_rey = 1'b1;
                if (next_pulse) state_d = S_SH_IMY;
            end
            S_SH_IMY: begin
                ctrl.display_imy = 1'b1;
                if (next_pulse) state_d = S_SH_REZ;
            end
            S_SH_REZ: begin
                ctrl.display_rez = 1'b1;
                ctrl.step        = STEP_SH_REZ;
                if (next_pulse) state_d = S_SH_IMZ;
            end
            S_SH_IMZ: begin
                ctrl.display_imz = 1'b1;
                ctrl.step        = STEP_SH_IMZ;
                if (next_pulse) state_d = S_WAIT_B;
            end
            default: begin
                ctrl.step = STEP_IDLE;
                state_d   = S_IDLE;
            end
        endcase
    end

    assign store_W     = ctrl.store_w;
    assign store_B     = ctrl.store_b;
    assign store_A     = ctrl.store_a;
    assign calc_ReWB   = ctrl.calc_rewb;
    assign calc_ImY    = ctrl.calc_imy;
    assign calc_ImZ    = ctrl.calc_imz;
    assign calc_ReY    = ctrl.calc_rey;
    assign calc_ReZ2   = ctrl.calc_rez2;
    assign calc_ReZ    = ctrl.calc_rez;
    assign display_ReY = ctrl.display_rey;
    assign display_ImY = ctrl.display_imy;
    assign display_ReZ = ctrl.display_rez;
    assign display_ImZ = ctrl.display_imz;
    assign clear       = ctrl.clear;
    assign busy        = ctrl.busy;
    assign step        = ctrl.step;

endmodule

// File: tb/tb_butterfly_controller.sv
// Bench for butterfly_controller: directed scenarios plus random Next activity,
// every cycle compared against a press-history reference model.
module tb_butterfly_controller;

    localparam int S = 2;
`ifdef NEXT_DEBOUNCE_EN
    localparam int D = 8;
`else
    localparam int D = 0;
`endif
    localparam int PLEN = D + 2;
    localparam int PGAP = D + S + 8;

    logic       Clock = 1'b0;
    logic       nReset = 1'b0;
    logic       Next = 1'b0;
    logic       store_W, store_B, store_A;
    logic       calc_ReWB, calc_ImY, calc_ImZ, calc_ReY, calc_ReZ2, calc_ReZ;
    logic       display_ReY, display_ImY, display_ReZ, display_ImZ;
    logic       clear, busy;
    logic [3:0] step;
    logic [12:0] strobes;

    always #5 Clock = ~Clock;

    butterfly_controller #(
        .SYNC_STAGES     (S),
        .DEBOUNCE_CYCLES (20'd8)
    ) dut (
        .Clock       (Clock),
        .nReset      (nReset),
        .Next        (Next),
        .store_W     (store_W),
        .store_B     (store_B),
        .store_A     (store_A),
        .calc_ReWB   (calc_ReWB),
        .calc_ImY    (calc_ImY),
        .calc_ImZ    (calc_ImZ),
        .calc_ReY    (calc_ReY),
        .calc_ReZ2   (calc_ReZ2),
        .calc_ReZ    (calc_ReZ),
        .display_ReY (display_ReY),
        .display_ImY (display_ImY),
        .display_ReZ (display_ReZ),
        .display_ImZ (display_ImZ),
        .clear       (clear),
        .busy        (busy),
        .step        (step)
    );

    assign strobes = {store_W, store_B, store_A, calc_ReWB, calc_ImY, calc_ImZ,
                      calc_ReY, calc_ReZ2, calc_ReZ,
                      display_ReY, display_ImY, display_ReZ, display_ImZ};

    int n_tests = 0;
    int n_fail  = 0;

    // Butterfly phase list: which strobe bit each phase raises (-1 none) and
    // whether the phase waits for a press.
    int M_STROBE [17] = '{-1, 12, 12, -1, 11, 9, 8, 7, -1, 10, 6, 5, 4, 3, 2, 1, 0};
    bit M_WAIT   [17] = '{1, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 1, 1, 1};

    bit nh[$];      // Next level seen at each clock edge since reset release
    int m_idx;
    bit m_level;
    bit m_pulse;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [12:0] exp_strobes(input int idx);
        logic [12:0] v;
        v = '0;
        if (M_STROBE[idx] >= 0) v[M_STROBE[idx]] = 1'b1;
        return v;
    endfunction

    function automatic int exp_step(input int idx);
        return (idx > 15) ? 15 : idx;
    endfunction

    function automatic bit sync_of(input int c);
        return (c - S >= 0) ? nh[c - S] : 1'b1;
    endfunction

    task automatic model_reset();
        nh.delete();
        m_idx   = 0;
        m_level = 1'b1;
        m_pulse = 1'b0;
    endtask

    task automatic tick();
        int e;
        bit v;
        bit all_same;
        bit new_level;
        @(posedge Clock);
        if (!M_WAIT[m_idx] || m_pulse) m_idx = (m_idx == 16) ? 3 : m_idx + 1;
        nh.push_back(Next);
        e = nh.size();
        if (D == 0) begin
            new_level = sync_of(e);
        end else begin
            new_level = m_level;
            if (e >= D) begin
                v = sync_of(e - 1);
                all_same = 1'b1;
                for (int c = e - D; c < e; c++) if (sync_of(c) != v) all_same = 1'b0;
                if (all_same && v != m_level) new_level = v;
            end
        end
        m_pulse = new_level & ~m_level;
        m_level = new_level;
        #1;
        check_eq("strobes", 32'(strobes), 32'(exp_strobes(m_idx)));
        check_eq("clear", 32'(clear), 32'(m_idx == 0));
        check_eq("busy", 32'(busy), 32'(!M_WAIT[m_idx]));
        check_eq("step", 32'(step), exp_step(m_idx));
        check_eq("one_strobe", 32'($countones(strobes) <= 1), 32'd1);
    endtask

    task automatic do_reset(input int n);
        nReset = 1'b0;
        Next   = 1'b0;
        #1;
        check_eq("rst_strobes", 32'(strobes), 32'd0);
        check_eq("rst_clear", 32'(clear), 32'd1);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_step", 32'(step), 32'd0);
        repeat (n) @(posedge Clock);
        #1;
        nReset = 1'b1;
        model_reset();
    endtask

    task automatic press(input int len, input int gap);
        Next = 1'b1;
        repeat (len) tick();
        Next = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic goto_phase(input int target);
        int guard;
        guard = 0;
        while (m_idx != target && guard < 100) begin
            if (M_WAIT[m_idx]) press(PLEN, PGAP);
            else tick();
            guard++;
        end
        check_eq("goto_phase", m_idx, target);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int cnt;
        bit found;
        model_reset();
        @(posedge Clock);
        do_reset(3);
        repeat (10) tick();
        check_eq("reset_idle_step", 32'(step), 32'd0);

        // one full butterfly: W, B, A, then four result presses
        repeat (7) press(PLEN, PGAP);
        check_eq("back_to_waitb", 32'(step), 32'd3);

`ifdef NEXT_DEBOUNCE_EN
        press(3, 20);
        check_eq("glitch_ignored", 32'(step), 32'd3);
        Next  = 1'b1;
        cnt   = 0;
        found = 1'b0;
        while (!found && cnt < 40) begin
            tick();
            cnt++;
            if (cnt == 10) Next = 1'b0;
            if (store_B) found = 1'b1;
        end
        Next = 1'b0;
        check_eq("deb_latency", cnt, D + S + 1);
        repeat (PGAP) tick();
        goto_phase(8);
`else
        // second pulse lands in C_IMY and must be dropped
        press(1, 2);
        press(3, 20);
        check_eq("busy_press_dropped", 32'(step), 32'd8);
`endif

        goto_phase(13);
        Next = 1'b1;
        repeat (200) tick();
        check_eq("held_one_step", 32'(step), 32'd14);
        Next = 1'b0;
        repeat (PGAP) tick();

        goto_phase(8);
        Next = 1'b1;
        cnt  = 0;
        while (m_idx != 10 && cnt < 60) begin
            tick();
            cnt++;
        end
        check_eq("reach_c_rey", 32'(step), 32'd10);
        do_reset(4);
        repeat (5) tick();
        Next  = 1'b1;
        cnt   = 0;
        found = 1'b0;
        while (!found && cnt < 40) begin
            tick();
            cnt++;
            if (cnt == PLEN) Next = 1'b0;
            if (store_W) found = 1'b1;
        end
        check_eq("post_rst_store_w", 32'(found), 32'd1);
        Next = 1'b0;
        repeat (PGAP) tick();

        repeat (400) begin
            if ($urandom_range(0, 59) == 0) do_reset($urandom_range(1, 3));
            Next = 1'($urandom_range(0, 1));
            repeat ($urandom_range(1, D + 6)) tick();
        end
        Next = 1'b0;
        repeat (PGAP) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
